serial_adder: RTL and testbench
===============================

# serial_adder

Parametrised multi-cycle adder/subtractor that adds two WIDTH-bit operands SLICE bits per clock, LSB slice first, through a chain of SLICE full-adder cells and a registered inter-slice carry. It sits wherever a narrow, area-cheap arithmetic unit is acceptable in place of a full-width ripple adder. It supports add and subtract modes, a start/busy/done handshake, carry-out and signed-overflow flags, and results held stable between operations.

## Interface
- WIDTH, 8: operand/result width in bits; ≥1.
- SLICE, 1: bits processed per clock; must divide WIDTH exactly, 1 ≤ SLICE ≤ WIDTH.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- start  input  1  request; sampled only in IDLE or DONE.
- sub  input  1  0 = add (ain+bin+cin), 1 = subtract (ain+~bin+1; cin ignored).
- cin  input  1  carry-in for add mode.
- ain  input  WIDTH  operand A.
- bin  input  WIDTH  operand B.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle completion pulse.
- sout  output  WIDTH  result.
- cout  output  1  carry out of MSB; in subtract mode 1 = no borrow.
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

## Operation
- STEPS = WIDTH/SLICE. FSM states: IDLE, RUN, DONE.
- IDLE/DONE with start=1: latch ain, bin (inverted if sub), carry ← sub ? 1 : cin, slice counter ← 0; go to RUN.
- DONE with start=0: go to IDLE.
- RUN: each clock, add the current SLICE-bit slice of A and B plus the carry register; shift the sum slice into an internal result shift register; update carry; increment counter. After the slice with counter = STEPS-1, go to DONE and load sout, cout, ovf simultaneously.
- start in RUN is ignored; operands are not re-sampled.
- Inputs ain/bin/sub/cin are don't-care except at the accepting edge.
- sout/cout/ovf change only on completion (or reset); they hold the last result otherwise, including while a new operation runs.
- Arithmetic is modulo 2^WIDTH; ovf is computed from the MSB cell's carry-in and carry-out of the final slice.

## Timing
- Reset (rst_n=0 at an edge): state IDLE, busy=0, done=0, sout=0, cout=0, ovf=0, internal registers 0. Applies mid-operation: operation aborted, no done pulse.
- Start accepted at edge k → busy=1 from edge k through edge k+STEPS-1; at edge k+STEPS: busy=0, done=1, results valid.
- done is high for exactly one cycle (edge k+STEPS to k+STEPS+1) unless a new start was accepted in that DONE cycle, in which case busy rises at k+STEPS+1 and done falls.
- Back-to-back throughput: one result per STEPS+1 clocks.
- WIDTH=SLICE gives STEPS=1: done one edge after start.

## Structure
- Package serial_adder_pkg: state encoding type (IDLE, RUN, DONE) and a function computing STEPS and counter width ($clog2(STEPS), minimum 1).
- Sub-module fa_cell: combinational full adder (cin, ain, bin → sout, cout); SLICE instances chained per cycle via generate.
- Elaboration-time check: WIDTH % SLICE ≠ 0 is an error.

## Test plan
- WIDTH=8, SLICE=1, add 0xFF+0x01, cin=0 → sout=0x00, cout=1, ovf=0, done exactly at edge k+8, busy high for 8 cycles.
- WIDTH=8, SLICE=1, add 0x7F+0x01 → sout=0x80, cout=0, ovf=1; add 0x0F+0x01 cin=1 → 0x11, cout=0, ovf=0.
- WIDTH=8, SLICE=4, sub 0x05−0x07 → sout=0xFE, cout=0, ovf=0, done at k+2; sub 0x80−0x01 → 0x7F, cout=1, ovf=1.
- WIDTH=1, SLICE=1, all 8 (cin, ain, bin) combinations in add mode → sout/cout match full-adder truth table, done at k+1 each.
- start held high through RUN → ignored, single done; start asserted in DONE cycle → new operation, next done at +STEPS+1, previous sout held until then.
- rst_n=0 at edge k+3 of an 8-step operation → all outputs 0 and IDLE next cycle, no done pulse; fresh start afterwards completes normally.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the slice-serial adder.
// Latency: n/a (package only).
// Backpressure: n/a.
package serial_adder_pkg;

  // Controller states: waiting, stepping through slices, presenting a result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of clocks needed to walk all slices of an operand.
  function automatic int calc_steps(input int width, input int slice);
    if (slice < 1) return 1;
    return width / slice;
  endfunction

  // Slice counter width; never below one bit so the counter always exists.
  function automatic int calc_cnt_w(input int width, input int slice);
    int s;
    s = calc_steps(width, slice);
    if (s <= 2) return 1;
    return $clog2(s);
  endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Single-bit full adder used as one link of the per-clock carry chain.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module fa_cell (
  input  logic cin,
  input  logic ain,
  input  logic bin,
  output logic sout,
  output logic cout
);

  assign sout = ain ^ bin ^ cin;
  assign cout = (ain & bin) | (cin & (ain ^ bin));

endmodule

// File: rtl/serial_adder.sv
// Adds/subtracts two WIDTH-bit operands SLICE bits per clock, LSB slice first.
// Latency: WIDTH/SLICE clocks from accepted start to done; one result per STEPS+1 clocks.
// Backpressure: start is only accepted in IDLE or DONE; it is ignored while busy.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sout,
  output logic             cout,
  output logic             ovf
);

  localparam int STEPS = calc_steps(WIDTH, SLICE);
  localparam int CW    = calc_cnt_w(WIDTH, SLICE);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  // Reject slice widths that do not tile the operand exactly.
  if ((SLICE < 1) || (SLICE > WIDTH) || ((WIDTH % SLICE) != 0)) begin : g_bad_param
    $error("serial_adder: SLICE must be in 1..WIDTH and divide WIDTH exactly");
  end

  state_t           state_q, state_d;
  logic             load, step, last_step;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_nxt;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [SLICE:0]   c;
  logic [SLICE-1:0] s_slice;

  // Carry chain for the current slice: the registered carry feeds cell 0.
  assign c[0] = carry_q;

  for (genvar i = 0; i < SLICE; i++) begin : g_cell
    fa_cell u_fa (
      .cin  (c[i]),
      .ain  (a_q[i]),
      .bin  (b_q[i]),
      .sout (s_slice[i]),
      .cout (c[i+1])
    );
  end

  // New sum slice enters at the MSB end so that after STEPS shifts the
  // first (LSB) slice has arrived at bit 0.
  if (WIDTH == SLICE) begin : g_res_full
    assign res_nxt = s_slice;
  end else begin : g_res_shift
    assign res_nxt = {s_slice, res_q[WIDTH-1:SLICE]};
  end

  assign last_step = (state_q == RUN) && (cnt_q == LAST);
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and datapath control; start is only looked at outside RUN.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand/carry/counter registers: load on accept, shift one slice per RUN clock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (load) begin
      a_q     <= ain;
      b_q     <= sub ? ~bin : bin;
      carry_q <= sub ? 1'b1 : cin;
      cnt_q   <= '0;
    end else if (step) begin
      a_q     <= a_q >> SLICE;
      b_q     <= b_q >> SLICE;
      res_q   <= res_nxt;
      carry_q <= c[SLICE];
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  // Visible results only move on the final slice, so they hold across new operations.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sout <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (last_step) begin
      sout <= res_nxt;
      cout <= c[SLICE];
      ovf  <= c[SLICE] ^ c[SLICE-1];
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder across three shapes: 8x1, 8x4 and 1x1.
// Latency: checks done/busy timing per operation against STEPS.
// Backpressure: exercises start held in RUN and start in the DONE cycle.
module tb_serial_adder;

  typedef struct packed {
    logic [1:0] d;
    logic [9:0] v;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_d [3];
  logic       sub_d   [3];
  logic       cin_d   [3];
  logic [7:0] ain_d   [3];
  logic [7:0] bin_d   [3];

  logic       busy0, busy1, busy2;
  logic       done0, done1, done2;
  logic [7:0] sout0, sout1;
  logic [0:0] sout2;
  logic       cout0, cout1, cout2;
  logic       ovf0, ovf1, ovf2;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .SLICE(1)) u_d0 (
    .clk(clk), .rst_n(rst_n), .start(start_d[0]), .sub(sub_d[0]), .cin(cin_d[0]),
    .ain(ain_d[0]), .bin(bin_d[0]), .busy(busy0), .done(done0),
    .sout(sout0), .cout(cout0), .ovf(ovf0)
  );

  serial_adder #(.WIDTH(8), .SLICE(4)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start_d[1]), .sub(sub_d[1]), .cin(cin_d[1]),
    .ain(ain_d[1]), .bin(bin_d[1]), .busy(busy1), .done(done1),
    .sout(sout1), .cout(cout1), .ovf(ovf1)
  );

  serial_adder #(.WIDTH(1), .SLICE(1)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(start_d[2]), .sub(sub_d[2]), .cin(cin_d[2]),
    .ain(ain_d[2][0:0]), .bin(bin_d[2][0:0]), .busy(busy2), .done(done2),
    .sout(sout2), .cout(cout2), .ovf(ovf2)
  );

  function automatic int steps_of(input int d);
    return (d == 0) ? 8 : (d == 1) ? 2 : 1;
  endfunction

  function automatic int width_of(input int d);
    return (d == 2) ? 1 : 8;
  endfunction

  // Reference: {sum[7:0], carry out, signed overflow}; overflow from operand/result signs.
  function automatic logic [9:0] model(input int w, input logic s, input logic ci,
                                       input logic [7:0] a, input logic [7:0] b);
    logic [8:0] mask, aa, bb, tot;
    logic [7:0] r;
    logic       c, v;
    mask = 9'((1 << w) - 1);
    aa   = {1'b0, a} & mask;
    bb   = s ? (~{1'b0, b} & mask) : ({1'b0, b} & mask);
    tot  = aa + bb + (s ? 9'd1 : {8'd0, ci});
    r    = tot[7:0] & mask[7:0];
    c    = tot[w];
    v    = (aa[w-1] == bb[w-1]) && (r[w-1] != aa[w-1]);
    return {r, c, v};
  endfunction

  function automatic logic [9:0] obs(input int d);
    case (d)
      0:       return {sout0, cout0, ovf0};
      1:       return {sout1, cout1, ovf1};
      default: return {7'd0, sout2, cout2, ovf2};
    endcase
  endfunction

  function automatic logic obs_busy(input int d);
    return (d == 0) ? busy0 : (d == 1) ? busy1 : busy2;
  endfunction

  function automatic logic obs_done(input int d);
    return (d == 0) ? done0 : (d == 1) ? done1 : done2;
  endfunction

  task automatic push_exp(input int d, input logic s, input logic ci,
                          input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.d = d[1:0];
    e.v = model(width_of(d), s, ci, a, b);
    sb_q.push_back(e);
  endtask

  task automatic pop_exp(input int d, output logic [9:0] v, output bit ok);
    exp_t e;
    if (sb_q.size() == 0) begin
      ok = 1'b0;
      v  = '0;
    end else begin
      e  = sb_q.pop_front();
      ok = (e.d == d[1:0]);
      v  = e.v;
    end
  endtask

  // Drive one operation, wait (bounded) for done; reports cycles to done and busy glitches.
  task automatic run_op(input int d, input logic s, input logic ci,
                        input logic [7:0] a, input logic [7:0] b,
                        output int cyc, output int busy_err);
    push_exp(d, s, ci, a, b);
    sub_d[d] = s; cin_d[d] = ci; ain_d[d] = a; bin_d[d] = b; start_d[d] = 1'b1;
    @(posedge clk); #1;
    start_d[d] = 1'b0;
    ain_d[d] = 8'($urandom); bin_d[d] = 8'($urandom);
    sub_d[d] = 1'($urandom); cin_d[d] = 1'($urandom);
    busy_err = (obs_busy(d) !== 1'b1) ? 1 : 0;
    cyc = 0;
    for (int i = 0; i < steps_of(d) + 4; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (obs_done(d) === 1'b1) break;
      if (obs_busy(d) !== 1'b1) busy_err++;
    end
    if (obs_busy(d) !== 1'b0) busy_err++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      total++;
      if ({obs_busy(d), obs_done(d), obs(d)} !== 12'd0) begin
        bad++;
        $display("FAIL reset_d%0d: got busy/done/result %h want 000",
                 d, {obs_busy(d), obs_done(d), obs(d)});
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Shared body for the table-driven tests: result, latency and busy per op.
  task automatic test_table(input string tag, input int d, input int n,
                            input logic [17:0] fixed [4], input int nfixed);
    logic [17:0] op;
    logic [9:0]  v;
    bit          ok;
    int          cyc, berr;
    for (int i = 0; i < n; i++) begin
      if (i < nfixed) op = fixed[i];
      else            op = 18'($urandom);
      if (d == 2) op = {1'b0, 1'($urandom), 16'd0} | 18'(i);
      if (d == 2) op = {1'b0, op[2], 7'd0, op[1], 7'd0, op[0]};
      run_op(d, op[17], op[16], op[15:8], op[7:0], cyc, berr);
      pop_exp(d, v, ok);
      total++;
      if (cyc != steps_of(d)) begin
        bad++;
        $display("FAIL %s_latency[%0d]: got %0d cycles want %0d", tag, i, cyc, steps_of(d));
      end
      total++;
      if (berr != 0) begin
        bad++;
        $display("FAIL %s_busy[%0d]: got %0d busy errors want 0", tag, i, berr);
      end
      total++;
      if (!ok || obs(d) !== v) begin
        bad++;
        $display("FAIL %s_result[%0d]: got %h want %h (sb ok=%0d)", tag, i, obs(d), v, ok);
      end
    end
  endtask

  task automatic test_add8;
    logic [17:0] f [4];
    f[0] = {1'b0, 1'b0, 8'hFF, 8'h01};
    f[1] = {1'b0, 1'b0, 8'h7F, 8'h01};
    f[2] = {1'b0, 1'b1, 8'h0F, 8'h01};
    f[3] = {1'b1, 1'b0, 8'h10, 8'h20};
    test_table("add8", 0, 9, f, 4);
  endtask

  task automatic test_sub4;
    logic [17:0] f [4];
    f[0] = {1'b1, 1'b0, 8'h05, 8'h07};
    f[1] = {1'b1, 1'b0, 8'h80, 8'h01};
    f[2] = {1'b1, 1'b1, 8'h00, 8'h00};
    f[3] = {1'b0, 1'b1, 8'hFF, 8'hFF};
    test_table("slice4", 1, 8, f, 4);
  endtask

  task automatic test_w1;
    logic [17:0] f [4];
    for (int i = 0; i < 4; i++) f[i] = '0;
    test_table("w1", 2, 8, f, 0);
  endtask

  task automatic test_start_held;
    logic [9:0] v, res;
    bit         ok;
    int         ndone, first;
    push_exp(0, 1'b0, 1'b0, 8'h3C, 8'h5A);
    sub_d[0] = 1'b0; cin_d[0] = 1'b0; ain_d[0] = 8'h3C; bin_d[0] = 8'h5A; start_d[0] = 1'b1;
    @(posedge clk); #1;
    ndone = 0; first = 0; res = '0;
    for (int i = 1; i <= 14; i++) begin
      if (i <= 7) begin
        ain_d[0] = 8'($urandom); bin_d[0] = 8'($urandom); sub_d[0] = 1'($urandom);
      end
      if (i == 8) start_d[0] = 1'b0;
      @(posedge clk); #1;
      if (obs_done(0) === 1'b1) begin
        ndone++;
        if (first == 0) begin
          first = i;
          res   = obs(0);
        end
      end
    end
    pop_exp(0, v, ok);
    total++;
    if (ndone != 1) begin
      bad++;
      $display("FAIL held_done_count: got %0d want 1", ndone);
    end
    total++;
    if (first != 8) begin
      bad++;
      $display("FAIL held_latency: got %0d want 8", first);
    end
    total++;
    if (!ok || res !== v) begin
      bad++;
      $display("FAIL held_result: got %h want %h", res, v);
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] v1, v2, prev;
    bit         ok1, ok2;
    int         cyc, berr, held_err, first;
    run_op(0, 1'b0, 1'b0, 8'h21, 8'h13, cyc, berr);
    pop_exp(0, v1, ok1);
    prev = obs(0);
    total++;
    if (!ok1 || prev !== v1 || cyc != 8) begin
      bad++;
      $display("FAIL b2b_first: got %h after %0d cycles want %h after 8", prev, cyc, v1);
    end
    push_exp(0, 1'b1, 1'b0, 8'h50, 8'h20);
    sub_d[0] = 1'b1; cin_d[0] = 1'b0; ain_d[0] = 8'h50; bin_d[0] = 8'h20; start_d[0] = 1'b1;
    @(posedge clk); #1;
    start_d[0] = 1'b0;
    total++;
    if ({obs_busy(0), obs_done(0)} !== 2'b10) begin
      bad++;
      $display("FAIL b2b_restart: got busy/done %b want 10", {obs_busy(0), obs_done(0)});
    end
    held_err = 0; first = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (obs_done(0) === 1'b1) begin
        first = i;
        break;
      end
      if (obs(0) !== v1) held_err++;
    end
    pop_exp(0, v2, ok2);
    total++;
    if (first != 8) begin
      bad++;
      $display("FAIL b2b_latency: got %0d want 8", first);
    end
    total++;
    if (held_err != 0) begin
      bad++;
      $display("FAIL b2b_hold: got %0d cycles with changed result want 0", held_err);
    end
    total++;
    if (!ok2 || obs(0) !== v2) begin
      bad++;
      $display("FAIL b2b_second: got %h want %h", obs(0), v2);
    end
  endtask

  task automatic test_reset_mid;
    logic [9:0] v;
    bit         ok;
    int         cyc, berr, stray;
    sub_d[0] = 1'b0; cin_d[0] = 1'b1; ain_d[0] = 8'hAA; bin_d[0] = 8'h11; start_d[0] = 1'b1;
    @(posedge clk); #1;
    start_d[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({obs_busy(0), obs_done(0), obs(0)} !== 12'd0) begin
      bad++;
      $display("FAIL midreset_clear: got %h want 000", {obs_busy(0), obs_done(0), obs(0)});
    end
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (obs_done(0) !== 1'b0 || obs_busy(0) !== 1'b0) stray++;
    end
    total++;
    if (stray != 0) begin
      bad++;
      $display("FAIL midreset_quiet: got %0d active cycles want 0", stray);
    end
    run_op(0, 1'b0, 1'b0, 8'h12, 8'h34, cyc, berr);
    pop_exp(0, v, ok);
    total++;
    if (!ok || obs(0) !== v || cyc != 8 || berr != 0) begin
      bad++;
      $display("FAIL midreset_fresh: got %h cyc=%0d busyerr=%0d want %h cyc=8 busyerr=0",
               obs(0), cyc, berr, v);
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      start_d[d] = 1'b0; sub_d[d] = 1'b0; cin_d[d] = 1'b0;
      ain_d[d] = 8'd0; bin_d[d] = 8'd0;
    end
    test_reset();
    test_add8();
    test_sub4();
    test_w1();
    test_start_held();
    test_back_to_back();
    test_reset_mid();
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d leftover want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
